// File: rtl/conv_enc_pkg.sv
// Shared definitions for the K=3 rate-1/2 convolutional code.
// Used by the encoder (conv_enc_k3) and by the Viterbi decoder to build its
// expected branch outputs.
package conv_enc_pkg;

  localparam int unsigned K      = 3;
  localparam int unsigned SR_W   = K - 1;
  localparam int unsigned TAIL_W = 2;
  localparam int unsigned CNT_W  = 16;

  // Generators; the MSB taps the current input bit.
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  // Code pair as it appears on the channel: {c1, c0}.
  typedef struct packed {
    logic c1;
    logic c0;
  } pair_t;

  // Parity of the generator-selected taps.
  function automatic logic conv_parity(input logic [K-1:0] v, input logic [K-1:0] g);
    return ^(v & g);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational encoder step: {u, sr} -> code pair and next shift register.
// Ports:
//   u          current information (or tail) bit
//   sr         shift register, sr[0] = most recent prior bit
//   pair_c     {c1, c0}
//   sr_next_c  shift register after this bit
module conv_enc_core
  import conv_enc_pkg::*;
(
  input  logic            u,
  input  logic [SR_W-1:0] sr,
  output pair_t           pair_c,
  output logic [SR_W-1:0] sr_next_c
);

  logic [K-1:0] v;

  // Tap vector ordered newest to oldest to match the generator bit order.
  assign v         = {u, sr[0], sr[1]};
  assign pair_c.c0 = conv_parity(v, G0);
  assign pair_c.c1 = conv_parity(v, G1);
  assign sr_next_c = {sr[0], u};

endmodule

// File: rtl/conv_enc_k3.sv
// Rate-1/2, K=3 convolutional encoder (G0=111, G1=101) with per-frame
// zero-tail termination and a single registered output slot.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake; in_bit, in_last payload
//   out_valid/out_ready   output handshake; out_pair {c1,c0}, out_last payload
//   busy                  frame open (DATA or TAIL)
// Optional (macro CONV_ENC_K3_FRAME_CNT_EN):
//   frame_pairs           pairs accepted in the current/last frame (saturating)
//   frame_done            one-cycle pulse after the last pair of a frame is taken
module conv_enc_k3
  import conv_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_pair,
  output logic       out_last,
  output logic       busy
`ifdef CONV_ENC_K3_FRAME_CNT_EN
  ,
  output logic [CNT_W-1:0] frame_pairs,
  output logic             frame_done
`endif
);

  state_t              state, state_d;
  logic [TAIL_W-1:0]   tail_cnt, tail_cnt_d;
  logic [SR_W-1:0]     sr, sr_d, sr_next;
  logic                valid_d, last_d;
  logic [1:0]          pair_d;
  logic                slot_free, xfer, load, enc_u;
  pair_t               enc_pair;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && (state != TAIL);
  assign xfer      = in_valid && in_ready;
  assign busy      = (state != IDLE);
  // Tail bits are forced to zero to flush the trellis back to state 0.
  assign enc_u     = (state == TAIL) ? 1'b0 : in_bit;

  conv_enc_core u_core (
    .u         (enc_u),
    .sr        (sr),
    .pair_c    (enc_pair),
    .sr_next_c (sr_next)
  );

  // State and output-slot register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tail_cnt  <= '0;
      sr        <= '0;
      out_valid <= 1'b0;
      out_pair  <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_d;
      tail_cnt  <= tail_cnt_d;
      sr        <= sr_d;
      out_valid <= valid_d;
      out_pair  <= pair_d;
      out_last  <= last_d;
    end
  end

  // Next-state, slot load/drain and tail sequencing.
  always_comb begin
    state_d    = state;
    tail_cnt_d = tail_cnt;
    sr_d       = sr;
    valid_d    = out_valid;
    pair_d     = out_pair;
    last_d     = out_last;
    load       = 1'b0;

    // Drained slot empties unless reloaded below in the same cycle.
    if (slot_free) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    case (state)
      IDLE, DATA: begin
        if (xfer) begin
          load    = 1'b1;
          state_d = DATA;
          if (in_last) begin
            state_d    = TAIL;
            tail_cnt_d = TAIL_W'(K - 1);
          end
        end
      end
      TAIL: begin
        if (slot_free) begin
          load       = 1'b1;
          tail_cnt_d = tail_cnt - TAIL_W'(1);
          if (tail_cnt == TAIL_W'(1)) begin
            last_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      valid_d = 1'b1;
      pair_d  = {enc_pair.c1, enc_pair.c0};
      sr_d    = sr_next;
    end
  end

`ifdef CONV_ENC_K3_FRAME_CNT_EN
  logic clear_pending;

  // Accepted-pair counter; holds the final count until the next frame's first pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_pairs   <= '0;
      frame_done    <= 1'b0;
      clear_pending <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_valid && out_ready) begin
        if (clear_pending) begin
          frame_pairs <= CNT_W'(1);
        end else if (frame_pairs != {CNT_W{1'b1}}) begin
          frame_pairs <= frame_pairs + CNT_W'(1);
        end
        clear_pending <= out_last;
        frame_done    <= out_last;
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_enc_k3.sv
// Directed bench for conv_enc_k3 with an expected-pair scoreboard.
module tb_conv_enc_k3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_last, busy;
  logic [1:0] out_pair;
`ifdef CONV_ENC_K3_FRAME_CNT_EN
  logic [15:0] frame_pairs;
  logic        frame_done;
  logic        done_seen = 1'b0;
  logic [15:0] done_val = '0;
`endif

  conv_enc_k3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pair  (out_pair),
    .out_last  (out_last),
    .busy      (busy)
`ifdef CONV_ENC_K3_FRAME_CNT_EN
    ,
    .frame_pairs (frame_pairs),
    .frame_done  (frame_done)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [2:0]  sb[$];      // {last, c1, c0}
  logic [1:0]  log_q[$];   // accepted pairs, in order
  logic [1:0]  exp_seq[$];
  logic [1:0]  m_sr = '0;  // model shift register, [0] = most recent
  int          rdy_mode = 0;
  logic        hold_valid = 1'b0;
  logic [2:0]  hold_val = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: c0 = u^s0^s1 (111), c1 = u^s1 (101).
  task automatic push_enc(input logic u, input logic last);
    logic c0, c1;
    c0 = u ^ m_sr[0] ^ m_sr[1];
    c1 = u ^ m_sr[1];
    sb.push_back({last, c1, c0});
    m_sr = {m_sr[0], u};
  endtask

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic send_bit(input logic u, input logic last, output int waits);
    bit done;
    done  = 0;
    waits = 0;
    in_valid = 1'b1; in_bit = u; in_last = last;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        push_enc(u, 1'b0);
        if (last) begin
          push_enc(1'b0, 1'b0);
          push_enc(1'b0, 1'b1);
        end
      end else begin
        waits++;
        if (waits >= 100) done = 1;
      end
      @(posedge clk); #1;
    end
    check("send_wait_bound", 32'(waits < 100), 1);
  endtask

  task automatic send_frame(input logic [7:0] bits, input int n);
    int w;
    for (int i = 0; i < n; i++) send_bit(bits[i], (i == n - 1), w);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_sb_empty"}, sb.size(), 0);
    @(negedge clk);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_sr"}, dut.sr, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, log_q.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < log_q.size(); i++)
      check($sformatf("%s_pair%0d", tag, i), log_q[i], exp_seq[i]);
    log_q.delete();
  endtask

  // out_ready pattern: held high, or toggling every cycle.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) out_ready = ~out_ready;
    else out_ready = 1'b1;
  end

  // Output monitor: stall stability and scoreboard compare.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_valid) begin
        check("stall_hold", {out_last, out_pair}, hold_val);
        check("stall_valid", out_valid, 1);
      end
      hold_valid = 1'b0;
      if (out_valid && !out_ready) begin
        hold_valid = 1'b1;
        hold_val   = {out_last, out_pair};
        check("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        log_q.push_back(out_pair);
        if (sb.size() == 0) check("unexpected_pair", {out_last, out_pair}, 32'hDEAD);
        else check("pair", {out_last, out_pair}, sb.pop_front());
      end
`ifdef CONV_ENC_K3_FRAME_CNT_EN
      if (frame_done) begin
        done_seen = 1'b1;
        done_val  = frame_pairs;
      end
`endif
    end
  end

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog observed=timeout expected=finish");
  end

  initial begin
    int w;
    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pair", out_pair, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Frame 1,0,1,1 with out_ready high.
    log_q.delete();
    send_frame(8'b0000_1101, 4);
    drain("t1");
    exp_seq = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3};
    check_log("t1");
`ifdef CONV_ENC_K3_FRAME_CNT_EN
    check("fc_done_seen", done_seen, 1);
    check("fc_pairs", done_val, 6);
`endif

    // Single-bit frame.
    send_frame(8'b0000_0001, 1);
    drain("t2");
    exp_seq = '{2'd3, 2'd1, 2'd3};
    check_log("t2");

    // Frame 1,0,1,1 with out_ready toggling.
    rdy_mode = 1;
    send_frame(8'b0000_1101, 4);
    drain("t3");
    rdy_mode = 0;
    exp_seq = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3};
    check_log("t3");
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back single-bit frames with in_valid held.
    send_bit(1'b1, 1'b1, w);
    send_bit(1'b1, 1'b1, w);
    check("t4_tail_stall_cycles", w, 2);
    in_valid = 1'b0; in_last = 1'b0;
    drain("t4");
    exp_seq = '{2'd3, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3};
    check_log("t4");

    // Reset after the second bit of a frame.
    send_bit(1'b1, 1'b0, w);
    send_bit(1'b0, 1'b0, w);
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 1);
    in_valid = 1'b0;
    sb.delete();
    m_sr = '0;
    hold_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    @(posedge clk); #1;
    send_frame(8'b0000_0001, 1);
    drain("t5");
    exp_seq = '{2'd3, 2'd1, 2'd3};
    check_log("t5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
